// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the cache-to-RAM arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } arb_state_t;

    localparam int DCACHE_PORT = 0;
    localparam int ICACHE_PORT = 1;
    localparam int WORD_BYTES  = 4;

    // Little-endian byte lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_rr_grant.sv
// rtl/mem_rr_grant.sv - two-requester round-robin grant
module mem_rr_grant (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // A lone requester wins outright; on a tie the port not granted last time wins.
    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes icache/dcache word requests onto a byte-wide RAM port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              cache_rw_flag_i,
    input  logic [2*ADDR_WIDTH-1:0] cache_addr_i,
    input  logic [63:0]             cache_w_data_i,
    input  logic [7:0]              cache_w_mask_i,
    output logic [63:0]             cache_r_data_o,
    output logic [1:0]              cache_busy_o,
    output logic [1:0]              cache_done_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [7:0]              ram_w_data_o,
    output logic                    ram_we_o,
    output logic                    ram_re_o,
    input  logic [7:0]              ram_r_data_i
);

    localparam logic [1:0] DRAIN_LAST = 2'(RAM_LATENCY - 1);

    arb_state_t             state;
    logic                   last_grant;
    logic                   gid;
    logic [1:0]             cnt;
    logic [ADDR_WIDTH-1:0]  base;
    logic [31:0]            wdata;
    logic [3:0]             wmask;
    logic [1:0]             req;
    logic                   grant_valid;
    logic                   grant_id;
    logic [RAM_LATENCY-1:0] re_pipe;
    logic [1:0]             cap_cnt;

    // A port still showing its done pulse is ignored so its held flag cannot retrigger.
    always_comb begin
        req[0] = (|cache_rw_flag_i[1:0]) && !cache_done_o[0];
        req[1] = (|cache_rw_flag_i[3:2]) && !cache_done_o[1];
    end

    mem_rr_grant u_grant (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Transaction FSM: grant in IDLE, four byte beats, optional read drain, then one done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            gid          <= 1'b0;
            cnt          <= 2'd0;
            base         <= '0;
            wdata        <= 32'd0;
            wmask        <= 4'd0;
            cache_busy_o <= 2'b00;
            cache_done_o <= 2'b00;
            ram_addr_o   <= '0;
            ram_w_data_o <= 8'd0;
            ram_we_o     <= 1'b0;
            ram_re_o     <= 1'b0;
        end else begin
            cache_done_o <= 2'b00;
            case (state)
                ST_IDLE: begin
                    ram_we_o <= 1'b0;
                    ram_re_o <= 1'b0;
                    if (grant_valid) begin
                        gid                    <= grant_id;
                        last_grant             <= grant_id;
                        cnt                    <= 2'd0;
                        cache_busy_o[grant_id] <= 1'b1;
                        base  <= cache_addr_i[grant_id*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
                        wdata <= cache_w_data_i[{grant_id, 5'b00000} +: 32];
                        wmask <= cache_w_mask_i[{grant_id, 2'b00} +: 4];
                        // The write bit wins, so flag 11 behaves as a write.
                        state <= cache_rw_flag_i[{grant_id, 1'b1}] ? ST_WR : ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE, ST_WR: begin
                    ram_addr_o   <= base + ADDR_WIDTH'(cnt);
                    ram_re_o     <= (state == ST_RD_ISSUE);
                    ram_we_o     <= (state == ST_WR) && wmask[cnt];
                    ram_w_data_o <= (state == ST_WR) ? word_byte(wdata, cnt) : 8'd0;
                    cnt          <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= (state == ST_WR) ? ST_DONE : ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    ram_re_o <= 1'b0;
                    if (cnt == DRAIN_LAST) begin
                        cnt   <= 2'd0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    ram_we_o          <= 1'b0;
                    ram_re_o          <= 1'b0;
                    cache_busy_o[gid] <= 1'b0;
                    cache_done_o[gid] <= 1'b1;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-return path: delay each issue strobe by the RAM latency and land bytes in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            re_pipe        <= '0;
            cap_cnt        <= 2'd0;
            cache_r_data_o <= 64'd0;
        end else begin
            re_pipe <= RAM_LATENCY'({re_pipe, ram_re_o});
            if (re_pipe[RAM_LATENCY-1]) begin
                cache_r_data_o[{gid, cap_cnt, 3'b000} +: 8] <= ram_r_data_i;
                cap_cnt <= cap_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        is_read;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  flag;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] r_data;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wd;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_rd;

    logic [3:0]  flag3;
    logic [63:0] addr3;
    logic [63:0] r_data3;
    logic [1:0]  busy3;
    logic [1:0]  done3;
    logic [31:0] ram_addr3;
    logic [7:0]  ram_wd3;
    logic        ram_we3;
    logic        ram_re3;
    logic [7:0]  ram_rd3;

    logic [7:0]  mem1 [0:1023];
    logic [7:0]  mem3 [0:1023];
    logic        init1 = 1'b0;
    logic        init3 = 1'b0;
    logic [7:0]  d1, d2;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int both_done_cnt = 0;
    int excl_cnt = 0;
    int we_count = 0;
    int re_count = 0;
    int busy0_count = 0;
    int done_count = 0;
    exp_t sb[$];

    mem_arbiter #(.ADDR_WIDTH(32), .RAM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .cache_rw_flag_i(flag), .cache_addr_i(addr),
        .cache_w_data_i(wdata), .cache_w_mask_i(wmask),
        .cache_r_data_o(r_data), .cache_busy_o(busy), .cache_done_o(done),
        .ram_addr_o(ram_addr), .ram_w_data_o(ram_wd),
        .ram_we_o(ram_we), .ram_re_o(ram_re), .ram_r_data_i(ram_rd)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .RAM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .cache_rw_flag_i(flag3), .cache_addr_i(addr3),
        .cache_w_data_i(64'd0), .cache_w_mask_i(8'd0),
        .cache_r_data_o(r_data3), .cache_busy_o(busy3), .cache_done_o(done3),
        .ram_addr_o(ram_addr3), .ram_w_data_o(ram_wd3),
        .ram_we_o(ram_we3), .ram_re_o(ram_re3), .ram_r_data_i(ram_rd3)
    );

    function automatic logic [7:0] ram_pat(input int a);
        case (a)
            'h100: return 8'h11;
            'h101: return 8'h22;
            'h102: return 8'h33;
            'h103: return 8'h44;
            'h104: return 8'h55;
            'h105: return 8'h66;
            'h106: return 8'h77;
            'h107: return 8'h88;
            default: return 8'(a) ^ 8'h5A;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!init1) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= ram_pat(i);
            init1 <= 1'b1;
        end else if (ram_we) begin
            mem1[ram_addr[9:0]] <= ram_wd;
        end
        ram_rd <= mem1[ram_addr[9:0]];
    end

    always @(posedge clk) begin
        if (!init3) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= ram_pat(i);
            init3 <= 1'b1;
        end else if (ram_we3) begin
            mem3[ram_addr3[9:0]] <= ram_wd3;
        end
        d1      <= mem3[ram_addr3[9:0]];
        d2      <= d1;
        ram_rd3 <= d2;
    end

    always @(negedge clk) begin
        if (done == 2'b11 || done3 == 2'b11) both_done_cnt <= both_done_cnt + 1;
        if ((ram_we && ram_re) || (ram_we3 && ram_re3)) excl_cnt <= excl_cnt + 1;
        if (ram_we) we_count <= we_count + 1;
        if (ram_re) re_count <= re_count + 1;
        if (busy[0] || done[0]) busy0_count <= busy0_count + 1;
        if (done != 2'b00) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic rd, input int lat);
        exp_t e;
        e.port = p; e.data = d; e.is_read = rd; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic drive(input int p, input logic [1:0] rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        flag[2*p +: 2]   = rw;
        addr[32*p +: 32] = a;
        wdata[32*p +: 32] = d;
        wmask[4*p +: 4]  = m;
    endtask

    task automatic run(input int n, input int budget);
        int seen;
        logic [1:0] drop;
        exp_t e;
        seen = 0;
        drop = 2'b00;
        for (int k = 0; k < budget && seen < n; k++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (drop[p]) flag[2*p +: 2] = 2'b00;
            drop = 2'b00;
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    drop[p] = 1'b1;
                    seen++;
                    if (sb.size() == 0) begin
                        n_assert++;
                        n_fail++;
                        $error("FAIL sb_empty: observed done on port %0d expected none", p);
                    end else begin
                        e = sb.pop_front();
                        check("done_port", 64'(p), 64'(e.port));
                        check("done_cycle", 64'(cyc), 64'(e.due));
                        if (e.is_read) check("rdata", 64'(r_data[32*p +: 32]), 64'(e.data));
                    end
                end
            end
        end
        check("run_complete", 64'(seen), 64'(n));
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) if (drop[p]) flag[2*p +: 2] = 2'b00;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        flag = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed time limit expected completion");
        $fatal(1);
    end

    initial begin
        int base_we, base_re, base_busy0, base_done, t0, lat;
        logic got;
        logic [31:0] got_data;

        rst = 1'b1;
        flag = 4'd0; addr = 64'd0; wdata = 64'd0; wmask = 8'd0;
        flag3 = 4'd0; addr3 = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_rdata", r_data, 64'd0);
        check("reset_ram_addr", 64'(ram_addr), 64'd0);
        check("reset_strobes", 64'({ram_we, ram_re}), 64'd0);
        check("reset_wdata", 64'(ram_wd), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // icache word read
        base_busy0 = busy0_count;
        drive(1, 2'b01, 32'h100, 32'd0, 4'd0);
        push(1, 32'h44332211, 1'b1, 7);
        run(1, 30);
        check("t1_port0_rdata", 64'(r_data[31:0]), 64'd0);

        // unaligned icache read fetches the aligned word
        drive(1, 2'b01, 32'h103, 32'd0, 4'd0);
        push(1, 32'h44332211, 1'b1, 7);
        run(1, 30);
        check("t1_port0_idle", 64'(busy0_count - base_busy0), 64'd0);

        // dcache masked write
        base_we = we_count;
        drive(0, 2'b10, 32'h200, 32'hAABBCCDD, 4'b0101);
        push(0, 32'd0, 1'b0, 6);
        run(1, 30);
        check("t2_we_count", 64'(we_count - base_we), 64'd2);
        check("t2_mem200", 64'(mem1[10'h200]), 64'hDD);
        check("t2_mem201", 64'(mem1[10'h201]), 64'(ram_pat('h201)));
        check("t2_mem202", 64'(mem1[10'h202]), 64'hBB);
        check("t2_mem203", 64'(mem1[10'h203]), 64'(ram_pat('h203)));

        // rw=11 treated as a full write
        base_re = re_count;
        drive(0, 2'b11, 32'h300, 32'h01020304, 4'b1111);
        push(0, 32'd0, 1'b0, 6);
        run(1, 30);
        check("t6_no_re", 64'(re_count - base_re), 64'd0);
        check("t6_mem300", 64'(mem1[10'h300]), 64'h04);
        check("t6_mem303", 64'(mem1[10'h303]), 64'h01);

        // tie right after reset: port0 first
        pulse_reset();
        drive(0, 2'b01, 32'h100, 32'd0, 4'd0);
        drive(1, 2'b01, 32'h104, 32'd0, 4'd0);
        push(0, 32'h44332211, 1'b1, 7);
        push(1, 32'h88776655, 1'b1, 14);
        run(2, 40);

        // dcache-only transaction leaves port0 as last grant
        drive(0, 2'b10, 32'h208, 32'h0, 4'b0000);
        push(0, 32'd0, 1'b0, 6);
        run(1, 30);

        // repeat tie: port1 first
        drive(0, 2'b01, 32'h104, 32'd0, 4'd0);
        drive(1, 2'b01, 32'h100, 32'd0, 4'd0);
        push(1, 32'h44332211, 1'b1, 7);
        push(0, 32'h88776655, 1'b1, 14);
        run(2, 40);

        // reset during read issue, then clean retry
        drive(1, 2'b01, 32'h100, 32'd0, 4'd0);
        t0 = cyc;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_mid_issue_re", 64'(ram_re), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        flag = 4'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_done", 64'(done), 64'd0);
        check("t5_abort_strobes", 64'({ram_we, ram_re}), 64'd0);
        check("t5_abort_rdata", r_data, 64'd0);
        base_done = done_count;
        base_re = re_count;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_count - base_done), 64'd0);
        check("t5_no_re", 64'(re_count - base_re), 64'd0);
        sb.delete();
        drive(1, 2'b01, 32'h100, 32'd0, 4'd0);
        push(1, 32'h44332211, 1'b1, 7);
        run(1, 30);

        // RAM_LATENCY=3 instance read
        flag3 = 4'b0100;
        addr3 = {32'h100, 32'h0};
        t0 = cyc;
        got = 1'b0;
        lat = 0;
        got_data = 32'd0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done3[1]) begin
                got = 1'b1;
                lat = cyc - t0;
                got_data = r_data3[63:32];
            end
        end
        @(posedge clk); #1;
        flag3 = 4'd0;
        check("t6_l3_done_seen", 64'(got), 64'd1);
        check("t6_l3_latency", 64'(lat), 64'd9);
        check("t6_l3_rdata", 64'(got_data), 64'h44332211);

        repeat (3) @(posedge clk);
        #1;
        check("never_both_done", 64'(both_done_cnt), 64'd0);
        check("strobe_exclusive", 64'(excl_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
